// File: rtl/watch_set_if.sv
// watch_set_if: button, live-time and load/display bundle between the watch front panel and watch_set_ctrl
interface watch_set_if;
  logic tick_1hz;
  logic btn_mode;
  logic btn_inc;
  logic btn_inc_held;
  logic [3:0] cur_hour_10;
  logic [3:0] cur_hour1;
  logic [3:0] cur_min_10;
  logic [3:0] cur_min1;
  logic run_en;
  logic load;
  logic [3:0] ld_hour_10;
  logic [3:0] ld_hour1;
  logic [3:0] ld_min_10;
  logic [3:0] ld_min1;
  logic [1:0] mode;
  logic blink_hour;
  logic blink_min;
  modport master (
    output tick_1hz, btn_mode, btn_inc, btn_inc_held,
    output cur_hour_10, cur_hour1, cur_min_10, cur_min1,
    input run_en, load, ld_hour_10, ld_hour1, ld_min_10, ld_min1, mode, blink_hour, blink_min
  );
  modport slave (
    input tick_1hz, btn_mode, btn_inc, btn_inc_held,
    input cur_hour_10, cur_hour1, cur_min_10, cur_min1,
    output run_en, load, ld_hour_10, ld_hour1, ld_min_10, ld_min1, mode, blink_hour, blink_min
  );
endinterface

// File: rtl/watch_set_ctrl.sv
// watch_set_ctrl: RUN/SET_H/SET_M/COMMIT time-setting sequencer; define AUTO_REPEAT_EN for held-button auto-repeat
module watch_set_ctrl #(
  parameter int TIMEOUT_S  = 30,
  parameter int REPEAT_CYC = 12_500_000
) (
  input logic clk,
  input logic rst,
  watch_set_if.slave w
);
  typedef enum logic [1:0] {RUN, SET_H, SET_M, COMMIT} state_t;
  state_t state;
  logic [7:0] idle;
  logic [7:0] h_nx;
  logic [7:0] m_nx;
  logic inc;
  logic edit;
  logic ph;
  assign edit = state == SET_H || state == SET_M;
  assign ph = w.blink_hour | w.blink_min;
  assign w.mode = state;
`ifdef AUTO_REPEAT_EN
  logic [31:0] rep_cnt;
  logic rep_step;
  assign rep_step = edit && w.btn_inc_held && rep_cnt == 32'(REPEAT_CYC - 1);
  assign inc = w.btn_inc | rep_step;
  always_ff @(posedge clk)
    rep_cnt <= (rst || !edit || !w.btn_inc_held || w.btn_mode || rep_step) ? 32'd0 : rep_cnt + 32'd1;
`else
  logic unused_held;
  assign unused_held = w.btn_inc_held | (REPEAT_CYC < 1);
  assign inc = w.btn_inc;
`endif
  // Anything outside 00..23 / 00..59 (including the wrap value) steps to 00.
  always_comb begin
    h_nx = (w.ld_hour_10 > 4'd2 || w.ld_hour1 > 4'd9 || (w.ld_hour_10 == 4'd2 && w.ld_hour1 > 4'd2)) ? 8'h00 :
           w.ld_hour1 == 4'd9 ? {w.ld_hour_10 + 4'd1, 4'd0} : {w.ld_hour_10, w.ld_hour1 + 4'd1};
    m_nx = (w.ld_min_10 > 4'd5 || w.ld_min1 > 4'd9 || (w.ld_min_10 == 4'd5 && w.ld_min1 == 4'd9)) ? 8'h00 :
           w.ld_min1 == 4'd9 ? {w.ld_min_10 + 4'd1, 4'd0} : {w.ld_min_10, w.ld_min1 + 4'd1};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      w.run_en <= 1'b1;
      w.load <= 1'b0;
      {w.ld_hour_10, w.ld_hour1, w.ld_min_10, w.ld_min1} <= 16'h0000;
      idle <= 8'd0;
      w.blink_hour <= 1'b0;
      w.blink_min <= 1'b0;
    end else begin
      w.load <= 1'b0;
      case (state)
        RUN: if (w.btn_mode) begin
          state <= SET_H;
          w.run_en <= 1'b0;
          {w.ld_hour_10, w.ld_hour1, w.ld_min_10, w.ld_min1} <= {w.cur_hour_10, w.cur_hour1, w.cur_min_10, w.cur_min1};
          idle <= 8'd0;
        end
        SET_H, SET_M: if (w.btn_mode) begin
          state <= state == SET_H ? SET_M : COMMIT;
          w.load <= state == SET_M;
          idle <= 8'd0;
          w.blink_hour <= 1'b0;
          w.blink_min <= 1'b0;
        end else if (inc) begin
          idle <= 8'd0;
          w.blink_hour <= 1'b0;
          w.blink_min <= 1'b0;
          if (state == SET_H) {w.ld_hour_10, w.ld_hour1} <= h_nx;
          else {w.ld_min_10, w.ld_min1} <= m_nx;
        end else if (w.tick_1hz) begin
          if (idle == 8'(TIMEOUT_S - 1)) begin
            state <= RUN;
            w.run_en <= 1'b1;
            idle <= 8'd0;
            w.blink_hour <= 1'b0;
            w.blink_min <= 1'b0;
          end else begin
            idle <= idle + 8'd1;
            w.blink_hour <= state == SET_H && !ph;
            w.blink_min <= state == SET_M && !ph;
          end
        end
        default: begin
          state <= RUN;
          w.run_en <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_watch_set_ctrl.sv
// tb_watch_set_ctrl: vector table driven through a scoreboard queue, TIMEOUT_S=5, REPEAT_CYC=4
module tb_watch_set_ctrl;
  typedef struct packed {
    logic run_en;
    logic load;
    logic [1:0] mode;
    logic [15:0] ld;
    logic bh;
    logic bn;
  } exp_t;
  typedef struct {
    logic [4:0] in;
    logic [15:0] cur;
    exp_t e;
  } vec_t;
  localparam logic [4:0] N = 5'b00000, R = 5'b10000, T = 5'b01000, M = 5'b00100, I = 5'b00010, H = 5'b00001;
  logic clk = 1'b0;
  logic rst = 1'b1;
  watch_set_if w();
  watch_set_ctrl #(.TIMEOUT_S(5), .REPEAT_CYC(4)) dut (.clk(clk), .rst(rst), .w(w));
  vec_t vecs[$];
  exp_t sb[$];
  logic [15:0] cur_v;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  task automatic v(input logic [4:0] in, input logic [1:0] m, input logic [15:0] ld,
                   input logic run, input logic load, input logic bh, input logic bn);
    vec_t x;
    x.in = in;
    x.cur = cur_v;
    x.e = {run, load, m, ld, bh, bn};
    vecs.push_back(x);
  endtask
  always @(posedge clk) begin
    exp_t e;
    exp_t got;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      got = {w.run_en, w.load, w.mode, w.ld_hour_10, w.ld_hour1, w.ld_min_10, w.ld_min1, w.blink_hour, w.blink_min};
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL vec%0d: got run_en=%b load=%b mode=%0d ld=%h bh=%b bm=%b, want run_en=%b load=%b mode=%0d ld=%h bh=%b bm=%b",
                 checks, got.run_en, got.load, got.mode, got.ld, got.bh, got.bn,
                 e.run_en, e.load, e.mode, e.ld, e.bh, e.bn);
      end
    end
  end
  initial begin
    int m;
    int rk;
    int waited;
    {w.tick_1hz, w.btn_mode, w.btn_inc, w.btn_inc_held} = 4'b0;
    {w.cur_hour_10, w.cur_hour1, w.cur_min_10, w.cur_min1} = 16'h0000;
    cur_v = 16'h1234;
    v(R, 0, 16'h0000, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) v(T, 0, 16'h0000, 1, 0, 0, 0);
    v(I, 0, 16'h0000, 1, 0, 0, 0);
    v(M, 1, 16'h1234, 0, 0, 0, 0);
    v(I, 1, 16'h1334, 0, 0, 0, 0);
    v(I, 1, 16'h1434, 0, 0, 0, 0);
    v(I, 1, 16'h1534, 0, 0, 0, 0);
    v(M, 2, 16'h1534, 0, 0, 0, 0);
    for (int i = 1; i <= 30; i++) begin
      m = (34 + i) % 60;
      v(I, 2, {8'h15, 4'(m / 10), 4'(m % 10)}, 0, 0, 0, 0);
    end
    v(M, 3, 16'h1504, 0, 1, 0, 0);
    v(N, 0, 16'h1504, 1, 0, 0, 0);
    cur_v = 16'h2359;
    v(M, 1, 16'h2359, 0, 0, 0, 0);
    v(I, 1, 16'h0059, 0, 0, 0, 0);
    v(M, 2, 16'h0059, 0, 0, 0, 0);
    v(I, 2, 16'h0000, 0, 0, 0, 0);
    v(M, 3, 16'h0000, 0, 1, 0, 0);
    v(N, 0, 16'h0000, 1, 0, 0, 0);
    cur_v = 16'h0915;
    v(M, 1, 16'h0915, 0, 0, 0, 0);
    v(T, 1, 16'h0915, 0, 0, 1, 0);
    v(T, 1, 16'h0915, 0, 0, 0, 0);
    v(T, 1, 16'h0915, 0, 0, 1, 0);
    v(T, 1, 16'h0915, 0, 0, 0, 0);
    v(T, 0, 16'h0915, 1, 0, 0, 0);
    v(M, 1, 16'h0915, 0, 0, 0, 0);
    v(T, 1, 16'h0915, 0, 0, 1, 0);
    v(T, 1, 16'h0915, 0, 0, 0, 0);
    v(T, 1, 16'h0915, 0, 0, 1, 0);
    v(T | I, 1, 16'h1015, 0, 0, 0, 0);
    v(T, 1, 16'h1015, 0, 0, 1, 0);
    v(M | I, 2, 16'h1015, 0, 0, 0, 0);
    v(T, 2, 16'h1015, 0, 0, 0, 1);
    v(I, 2, 16'h1016, 0, 0, 0, 0);
    v(R, 0, 16'h0000, 1, 0, 0, 0);
    v(N, 0, 16'h0000, 1, 0, 0, 0);
    cur_v = 16'h2975;
    v(M, 1, 16'h2975, 0, 0, 0, 0);
    v(I, 1, 16'h0075, 0, 0, 0, 0);
    v(M, 2, 16'h0075, 0, 0, 0, 0);
    v(I, 2, 16'h0000, 0, 0, 0, 0);
    v(M, 3, 16'h0000, 0, 1, 0, 0);
    v(I, 0, 16'h0000, 1, 0, 0, 0);
    v(I, 0, 16'h0000, 1, 0, 0, 0);
    cur_v = 16'h1010;
    v(M, 1, 16'h1010, 0, 0, 0, 0);
    v(M, 2, 16'h1010, 0, 0, 0, 0);
    for (int k = 1; k <= 13; k++) begin
`ifdef AUTO_REPEAT_EN
      rk = k / 4;
`else
      rk = 0;
`endif
      v(H, 2, {8'h10, 4'd1, 4'(rk)}, 0, 0, 0, 0);
    end
    v(N, 2, {8'h10, 4'd1, 4'(rk)}, 0, 0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (w.run_en !== 1'b1 || w.load !== 1'b0 || w.mode !== 2'd0 || w.blink_hour !== 1'b0 || w.blink_min !== 1'b0 ||
        {w.ld_hour_10, w.ld_hour1, w.ld_min_10, w.ld_min1} !== 16'h0000) begin
      failures++;
      $display("FAIL reset state: run_en=%b load=%b mode=%0d bh=%b bm=%b", w.run_en, w.load, w.mode, w.blink_hour, w.blink_min);
    end
    foreach (vecs[i]) begin
      @(negedge clk);
      {rst, w.tick_1hz, w.btn_mode, w.btn_inc, w.btn_inc_held} = vecs[i].in;
      {w.cur_hour_10, w.cur_hour1, w.cur_min_10, w.cur_min1} = vecs[i].cur;
      sb.push_back(vecs[i].e);
    end
    @(negedge clk);
    {rst, w.tick_1hz, w.btn_mode, w.btn_inc, w.btn_inc_held} = N;
    waited = 0;
    while (sb.size() > 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL timeout: %0d expectations still pending", sb.size());
    end
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
